steer_en_v2: RTL and testbench
==============================

Name: steer_en_v2

Overview:
Parametrised second-generation steering-enable block. It sums and differences the left and right load-cell readings, applies weight hysteresis and imbalance thresholds, and runs an integrated settle-timer state machine. The result gates the steering contribution in the balance controller and reports rider presence to the power/auth logic. Compared with generation 1, it adds configurable widths, thresholds and settle time, registered input sampling, a saturating timer, a state/status output and a persistent-imbalance fault.

Parameters:
LD_W, 12, load-cell reading width in bits (8..16)
MIN_RIDER_WT, 512, nominal minimum rider weight (sum units)
WT_HYST, 64, hysteresis half-band; upper = MIN+HYST, lower = MIN-HYST
ON_SHIFT, 2, enable-blocking imbalance threshold = sum>>ON_SHIFT (1/4)
OFF_SHIFT, 4, disable threshold = sum - (sum>>OFF_SHIFT) (15/16)
SETTLE_CYCLES, 67108864, settle time in clk cycles before steering enables
FAST_SIM, 1, when 1 the settle time is 32768 cycles instead of SETTLE_CYCLES
FAULT_CYCLES, 1024, consecutive STEER-state cycles with diff > 1/4 before fault

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
lft_ld  in  LD_W  left load-cell reading, unsigned
rght_ld  in  LD_W  right load-cell reading, unsigned
en_steer  out  1  steering enabled
rider_off  out  1  no rider detected
state_o  out  2  current state: 00 IDLE, 01 WAIT, 10 STEER
imb_fault  out  1  sticky persistent-imbalance flag

Behaviour:
- Reset (async, rst=1): lft_q/rght_q=0, state=IDLE, timer=0, fault counter=0. Outputs: en_steer=0, rider_off=1, state_o=00, imb_fault=0.
- Input stage: lft_ld/rght_ld are registered every clk into lft_q/rght_q. All comparisons use the registered values.
- Arithmetic:
  - sum = lft_q + rght_q, LD_W+1 bits, no overflow.
  - diff = rght_q - lft_q, signed LD_W+1 bits.
  - absd = |diff|, unsigned LD_W+1 bits.
  - sum_gt = sum > MIN+HYST (strict).
  - sum_lt = sum < MIN-HYST (strict).
  - d_on = absd > (sum>>ON_SHIFT) (strict).
  - d_off = absd > sum - (sum>>OFF_SHIFT) (strict). Shifts truncate.
- Timer: TC = FAST_SIM ? 32768 : SETTLE_CYCLES. Width is $clog2(TC)+1.
  - Cleared when the state machine requests clr; otherwise increments.
  - Saturates at TC-1 and does not wrap.
  - tmr_full = (timer == TC-1).
- State machine (Moore; next state evaluated each clk, priority top to bottom):
  - IDLE:
    - sum_gt -> WAIT, clr timer.
    - else stay.
  - WAIT:
    - sum_lt -> IDLE.
    - d_on -> stay, clr timer.
    - tmr_full -> STEER.
    - else stay, timer counts.
  - STEER:
    - sum_lt -> IDLE.
    - d_off -> WAIT, clr timer.
    - else stay.
- Outputs are decoded from the state register only:
  - en_steer = (state==STEER).
  - rider_off = (state==IDLE).
  - state_o = state.
- Latency:
  - Input change at edge k is sampled at k, affects state at k+1, and is visible on outputs after k+1 (2 edges total).
  - From entering WAIT with a balanced load, en_steer rises TC cycles later.
- Fault:
  - Counter increments each cycle state==STEER && d_on && !d_off. It saturates at FAULT_CYCLES.
  - Cleared on any other cycle.
  - When it reaches FAULT_CYCLES, imb_fault sets and holds until rst. imb_fault does not alter state.
- Boundary conditions:
  - sum exactly equal to either threshold: neither sum_gt nor sum_lt.
  - absd exactly equal to a threshold: not exceeded.
  - sum=0: both imbalance thresholds are 0, so any nonzero absd exceeds them; the rider is off anyway.
  - Simultaneous sum_lt and d_off in STEER: IDLE wins.
  - Timer saturated in WAIT while d_on: clr still applies.
  - rst asserted mid-operation: immediate return to reset values regardless of clk.
  - Max inputs (all ones): sum = 2^(LD_W+1)-2, no overflow.

Test Plan:
- Reset: rst=1 with inputs 0x300/0x300 -> en_steer=0, rider_off=1, state_o=00, imb_fault=0 throughout. After release, state_o=01 two edges later.
- Balanced mount (defaults, FAST_SIM=1): lft=rght=0x150 (sum 0x2A0>0x240) -> WAIT, then en_steer=1 exactly 32768 cycles after entering WAIT, rider_off=0.
- Hysteresis: from STEER, drop sum to 0x1C0 (=lower) -> stays STEER. Sum 0x1BF -> IDLE within 2 edges. Raising to 0x240 (=upper) stays IDLE; 0x241 -> WAIT.
- Imbalance in WAIT: lft=0x100, rght=0x1A0 (sum 0x2A0, absd 0xA0 > 0xA8? no -> counts). Then lft=0x0F0, rght=0x1B0 (absd 0xC0 > 0xA8) -> timer clears each cycle, en_steer never rises while held.
- Step-off in STEER: lft=0x000, rght=0x300 (absd 0x300 > 0x2D0) -> WAIT, en_steer=0. Both to 0 with d_off simultaneous -> IDLE.
- Fault: in STEER hold lft=0x0F0, rght=0x1B0 for 1024 cycles -> imb_fault=1 on cycle 1024, state stays STEER. Rebalance -> imb_fault stays 1 until rst.

Source files
------------

// File: rtl/steer_en_v2.sv
// steer_en_v2: steering-enable controller.
// Registers the left/right load-cell readings and forms their sum and absolute
// difference. Rider-weight hysteresis and imbalance thresholds feed a three-state
// settle FSM, and a separate counter raises a sticky persistent-imbalance fault.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no rider on the board; steering off, rider_off asserted
// WAIT   | rider present; settle timer runs while the load stays balanced
// STEER  | settled; steering contribution enabled
module steer_en_v2 #(
  parameter int LD_W          = 12,
  parameter int MIN_RIDER_WT  = 512,
  parameter int WT_HYST       = 64,
  parameter int ON_SHIFT      = 2,
  parameter int OFF_SHIFT     = 4,
  parameter int SETTLE_CYCLES = 67108864,
  parameter int FAST_SIM      = 1,
  parameter int FAULT_CYCLES  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      state_o,
  output logic            imb_fault
);

  localparam int SW = LD_W + 1;
  localparam int TC = (FAST_SIM != 0) ? 32768 : SETTLE_CYCLES;
  localparam int TW = $clog2(TC) + 1;
  localparam int FW = $clog2(FAULT_CYCLES + 1);

  localparam logic [SW-1:0] WT_UPPER = SW'(MIN_RIDER_WT + WT_HYST);
  localparam logic [SW-1:0] WT_LOWER = SW'(MIN_RIDER_WT - WT_HYST);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TC - 1);
  localparam logic [FW-1:0] FLT_MAX  = FW'(FAULT_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_STEER = 2'b10;

  logic [LD_W-1:0] lft_q, rght_q;
  logic [1:0]      state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic            imb_fault_q, imb_fault_d;

  logic [SW-1:0]   sum, absd, on_thr, off_thr;
  logic            sum_gt, sum_lt, d_on, d_off;
  logic            tmr_full, tmr_clr, flt_cond;

  // Input sampling: every decision below uses the registered readings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end

  // Sum/difference and threshold compares; one extra bit keeps the sum exact.
  always_comb begin
    sum     = {1'b0, lft_q} + {1'b0, rght_q};
    absd    = (rght_q >= lft_q) ? ({1'b0, rght_q} - {1'b0, lft_q})
                                : ({1'b0, lft_q} - {1'b0, rght_q});
    on_thr  = sum >> ON_SHIFT;
    off_thr = sum - (sum >> OFF_SHIFT);
    sum_gt  = (sum > WT_UPPER);
    sum_lt  = (sum < WT_LOWER);
    d_on    = (absd > on_thr);
    d_off   = (absd > off_thr);
  end

  assign tmr_full = (tmr_q == TMR_MAX);

  // Next-state logic; rider loss has priority over imbalance in every state.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sum_gt) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (sum_lt) begin
          state_d = ST_IDLE;
        end else if (d_on) begin
          tmr_clr = 1'b1;
        end else if (tmr_full) begin
          state_d = ST_STEER;
        end
      end
      ST_STEER: begin
        if (sum_lt) begin
          state_d = ST_IDLE;
        end else if (d_off) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Settle timer: cleared on request, otherwise counts up and parks at TC-1.
  always_comb begin
    if (tmr_clr) begin
      tmr_d = '0;
    end else if (tmr_full) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  // Fault run-length: moderate imbalance while steering; any break restarts it.
  always_comb begin
    flt_cond = (state_q == ST_STEER) && d_on && !d_off;
    if (!flt_cond) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FLT_MAX) begin
      flt_cnt_d = flt_cnt_q;
    end else begin
      flt_cnt_d = flt_cnt_q + FW'(1);
    end
    imb_fault_d = imb_fault_q | (flt_cnt_d == FLT_MAX);
  end

  // State, timer and fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      flt_cnt_q   <= '0;
      imb_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      flt_cnt_q   <= flt_cnt_d;
      imb_fault_q <= imb_fault_d;
    end
  end

  // Moore outputs decoded from the state register only.
  assign en_steer  = (state_q == ST_STEER);
  assign rider_off = (state_q == ST_IDLE);
  assign state_o   = state_q;
  assign imb_fault = imb_fault_q;

endmodule

// File: tb/tb_steer_en_v2.sv
// Bench for steer_en_v2: directed scenarios plus random loads. A per-cycle
// behavioural model predicts the outputs, and a monitor pops the predictions
// and compares them against the DUT on the falling edge.
module tb_steer_en_v2;

  localparam int LD_W  = 12;
  localparam int W_MIN = 512;
  localparam int W_HYS = 64;
  localparam int TC    = 32768;
  localparam int FC    = 1024;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_STEER = 2;

  logic            clk;
  logic            rst;
  logic [LD_W-1:0] lft_ld, rght_ld;
  logic            en_steer, rider_off, imb_fault;
  logic [1:0]      state_o;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];

  // reference model state
  int ms, mt, mf, mlq, mrq;
  bit mflag;

  steer_en_v2 dut (
    .clk       (clk),
    .rst       (rst),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off),
    .state_o   (state_o),
    .imb_fault (imb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    st = 2'(ms);
    return {ms == M_STEER, ms == M_IDLE, st, mflag};
  endfunction

  task automatic model_reset();
    ms = M_IDLE; mt = 0; mf = 0; mlq = 0; mrq = 0; mflag = 0;
  endtask

  // One clock edge of the behaviour, computed with plain integer arithmetic.
  task automatic model_edge(input int l, input int r);
    int s, ad, ns;
    bit gt, lt, don, doff, clr;
    s    = mlq + mrq;
    ad   = (mrq > mlq) ? mrq - mlq : mlq - mrq;
    gt   = s > W_MIN + W_HYS;
    lt   = s < W_MIN - W_HYS;
    don  = ad > s / 4;
    doff = ad > s - s / 16;
    clr  = 0;
    ns   = ms;
    if (ms == M_IDLE) begin
      if (gt) begin ns = M_WAIT; clr = 1; end
    end else if (ms == M_WAIT) begin
      if (lt) ns = M_IDLE;
      else if (don) clr = 1;
      else if (mt == TC - 1) ns = M_STEER;
    end else begin
      if (lt) ns = M_IDLE;
      else if (doff) begin ns = M_WAIT; clr = 1; end
    end
    if (ms == M_STEER && don && !doff) begin
      if (mf < FC) mf++;
      if (mf == FC) mflag = 1;
    end else begin
      mf = 0;
    end
    if (clr) mt = 0;
    else if (mt < TC - 1) mt++;
    ms  = ns;
    mlq = l;
    mrq = r;
  endtask

  // Apply one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic cyc(input int l, input int r);
    lft_ld  = LD_W'(l);
    rght_ld = LD_W'(r);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_edge(l, r);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int l, input int r, input int n);
    for (int i = 0; i < n; i++) cyc(l, r);
  endtask

  // Monitor: one prediction per cycle, compared away from the active edge.
  always @(negedge clk) begin
    logic [4:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {en_steer, rider_off, state_o, imb_fault};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t en/off/st/flt actual=%b required=%b", $time, g, e);
      end
    end
  end

  initial begin
    logic [4:0] g;
    int l, r, b;
    model_reset();
    rst = 1'b1;
    lft_ld = '0;
    rght_ld = '0;

    // reset held with a heavy load present
    run(12'h300, 12'h300, 5);
    rst = 1'b0;
    run(12'h300, 12'h300, 2);

    // balanced mount, then sub-threshold and over-threshold imbalance in WAIT
    run(12'h150, 12'h150, 200);
    run(12'h100, 12'h1A0, 500);
    run(12'h0F0, 12'h1B0, 1000);
    run(12'h150, 12'h150, TC + 10);

    // persistent imbalance in STEER, then rebalance
    run(12'h0F0, 12'h1B0, FC + 80);
    run(12'h150, 12'h150, 20);

    // sum exactly at lower threshold stays in STEER
    run(12'h0E0, 12'h0E0, 20);

    // step-off to one side -> WAIT, then settle again
    run(12'h000, 12'h300, 20);
    run(12'h150, 12'h150, TC + 10);

    // sum below lower threshold with simultaneous d_off -> IDLE
    run(12'h000, 12'h1BF, 10);

    // sum exactly at upper threshold stays IDLE, one above -> WAIT
    run(12'h120, 12'h120, 10);
    run(12'h120, 12'h121, 10);

    // maximum inputs
    run(12'hFFF, 12'hFFF, 10);
    run(12'h000, 12'hFFF, 10);

    // random loads clustered around the weight thresholds
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        l = $urandom_range(0, 12'hFFF);
        r = $urandom_range(0, 12'hFFF);
      end else begin
        b = $urandom_range(12'h0D0, 12'h130);
        l = b - $urandom_range(0, 12'h40);
        r = b + $urandom_range(0, 12'h40);
      end
      run(l, r, $urandom_range(1, 6));
    end

    // asynchronous reset mid-operation, checked before any clock edge
    run(12'h150, 12'h150, 5);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    g = {en_steer, rider_off, state_o, imb_fault};
    n_vec++;
    if (g !== 5'b01000) begin
      n_err++;
      $display("FAIL async_reset actual=%b required=%b", g, 5'b01000);
    end
    model_reset();
    run(12'h150, 12'h150, 3);
    rst = 1'b0;
    run(12'h150, 12'h150, 5);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
